// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

    typedef enum logic {COLLECT, HOLD} pack_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int RX_FIFO_ADDR_W = 4;

endpackage

// File: rtl/uart_rx_packer_if.sv
// Byte-strobe input side and word valid/ready output side of the packer.
interface uart_rx_packer_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;

    modport master (
        output in_data, in_valid, word_ready,
        input  word_data, word_valid
    );

    modport slave (
        input  in_data, in_valid, word_ready,
        output word_data, word_valid
    );

endinterface

// File: rtl/rx_byte_fifo.sv
// Circular byte buffer with registered pointers and a combinational read port at rptr.
module rx_byte_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] wptr_q, rptr_q;
    logic [ADDR_W:0]   level_q;
    logic              do_push, do_pop;

    // A push into a full buffer is only taken when a pop frees a slot on the same edge.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + ADDR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
                2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdata = mem[rptr_q];
    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH);
    assign level = level_q;

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes into 32-bit big-endian words behind a valid/ready handshake.
// Optional sticky overrun flag (ovr/ovr_clr) is built when RX_OVERRUN_DETECT_EN is defined.
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int ADDR_W = RX_FIFO_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    uart_rx_packer_if.slave   bus,
    input  logic              flush,
`ifdef RX_OVERRUN_DETECT_EN
    output logic              ovr,
    input  logic              ovr_clr,
`endif
    output logic [ADDR_W:0]   fifo_level
);

    localparam int              CNT_W     = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    pack_state_t      state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q;
    logic [31:0]      pack_q, word_data_q;
    logic             word_valid_q;
    logic             push, pop, load_word, accept;
    logic             fifo_empty, fifo_full, drop_byte;
    logic [7:0]       fifo_rdata;

    assign push      = bus.in_valid & ~flush;
    assign drop_byte = push & fifo_full & ~pop;

    rx_byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_data),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_word = 1'b0;
        accept    = 1'b0;
        case (state_q)
            COLLECT: begin
                pop = ~fifo_empty;
                if (pop && byte_cnt_q == LAST_BYTE) begin
                    load_word = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    accept  = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        if (flush) begin
            pop       = 1'b0;
            load_word = 1'b0;
            accept    = 1'b0;
            state_d   = COLLECT;
        end
    end

    // The byte counter wraps to zero on the fourth pop, exactly when the word is loaded.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byte_cnt_q   <= '0;
            pack_q       <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else if (flush) begin
            byte_cnt_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                pack_q     <= {pack_q[23:0], fifo_rdata};
                byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            end
            if (load_word) begin
                word_data_q  <= {pack_q[23:0], fifo_rdata};
                word_valid_q <= 1'b1;
            end else if (accept) begin
                word_valid_q <= 1'b0;
            end
        end
    end

    assign bus.word_data  = word_data_q;
    assign bus.word_valid = word_valid_q;

`ifdef RX_OVERRUN_DETECT_EN
    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovr <= 1'b0;
        end else if (drop_byte) begin
            ovr <= 1'b1;
        end else if (ovr_clr) begin
            ovr <= 1'b0;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_byte;
`endif

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized self-checking bench for uart_rx_packer against a queue-based byte/word model.
module tb_uart_rx_packer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic             CLK;
    logic             RST_N;
    logic             flush;
    logic             ovr_clr;
    logic [ADDR_W:0]  fifo_level;
`ifdef RX_OVERRUN_DETECT_EN
    logic             ovr;
`endif

    uart_rx_packer_if bus ();

    uart_rx_packer #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .bus        (bus.slave),
        .flush      (flush),
`ifdef RX_OVERRUN_DETECT_EN
        .ovr        (ovr),
        .ovr_clr    (ovr_clr),
`endif
        .fifo_level (fifo_level)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_q[$];
    logic [7:0]  m_coll[$];
    logic        m_holding;
    logic [31:0] m_word;
    logic        m_ovr;

    logic [7:0]  exp_bytes[$];
    logic [31:0] got_words[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_coll.delete();
        m_holding = 1'b0;
        m_word    = '0;
        m_ovr     = 1'b0;
    endtask

    // One clock edge of the packer expressed as byte/word queue operations.
    task automatic model_step();
        int pre;
        bit popped;
        bit dropped;
        pre     = m_q.size();
        popped  = 1'b0;
        dropped = 1'b0;
        if (flush) begin
            m_q.delete();
            m_coll.delete();
            m_holding = 1'b0;
        end else begin
            if (!m_holding && pre > 0) begin
                popped = 1'b1;
                m_coll.push_back(m_q.pop_front());
                if (m_coll.size() == 4) begin
                    m_word    = {m_coll[0], m_coll[1], m_coll[2], m_coll[3]};
                    m_holding = 1'b1;
                    m_coll.delete();
                end
            end else if (m_holding && bus.word_ready) begin
                m_holding = 1'b0;
            end
            if (bus.in_valid) begin
                if (pre < DEPTH || popped) m_q.push_back(bus.in_data);
                else dropped = 1'b1;
            end
        end
        if (dropped) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model; also records accepted words in order.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N) begin
                check_output("level", 32'(fifo_level), 32'(m_q.size()));
                check_output("word_valid", 32'(bus.word_valid), 32'(m_holding));
                check_output("word_data", bus.word_data, m_word);
`ifdef RX_OVERRUN_DETECT_EN
                check_output("ovr", 32'(ovr), 32'(m_ovr));
`endif
                if (bus.word_valid && bus.word_ready) got_words.push_back(bus.word_data);
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic rdy,
                                  input logic fl, input logic clr);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.word_ready = rdy;
        flush          = fl;
        ovr_clr        = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] seq [4];
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.word_ready = 1'b0;
        flush          = 1'b0;
        ovr_clr        = 1'b0;
        RST_N          = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        $display("[TB] reset values");
        check_output("rst_level", 32'(fifo_level), 32'd0);
        check_output("rst_valid", 32'(bus.word_valid), 32'd0);
        check_output("rst_data", bus.word_data, 32'h0);

        $display("[TB] spaced bytes");
        idle(2, 1'b0);
        seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
            idle(9, 1'b0);
        end
        check_output("spaced_word", bus.word_data, 32'h12345678);
        check_output("spaced_valid", 32'(bus.word_valid), 32'd1);
        check_output("spaced_level", 32'(fifo_level), 32'd0);
        idle(5, 1'b0);
        check_output("spaced_hold", bus.word_data, 32'h12345678);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_output("spaced_accept", 32'(bus.word_valid), 32'd0);
        idle(2, 1'b0);

        $display("[TB] overrun and full-with-pop");
        got_words.delete();
        exp_bytes.delete();
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            apply_stimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
        end
        check_output("full_level", 32'(fifo_level), 32'd16);
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        check_output("drop_level", 32'(fifo_level), 32'd16);
`ifdef RX_OVERRUN_DETECT_EN
        check_output("ovr_set", 32'(ovr), 32'd1);
`endif
        apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
`ifdef RX_OVERRUN_DETECT_EN
        check_output("ovr_set_wins", 32'(ovr), 32'd1);
`endif
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef RX_OVERRUN_DETECT_EN
        check_output("ovr_clear", 32'(ovr), 32'd0);
`endif
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_output("accept_no_pop", 32'(fifo_level), 32'd16);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            apply_stimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
            if (i == 0) check_output("full_push_pop_level", 32'(fifo_level), 32'd16);
        end
        idle(60, 1'b1);
        check_output("drain_count", 32'(got_words.size()), 32'd6);
        for (int w = 0; w < 6; w++) begin
            check_output($sformatf("drain_word%0d", w), got_words[w],
                         {exp_bytes[4*w], exp_bytes[4*w+1], exp_bytes[4*w+2], exp_bytes[4*w+3]});
        end
        check_output("drain_level", 32'(fifo_level), 32'd0);

        $display("[TB] flush discards partial word");
        idle(2, 1'b0);
        apply_stimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        apply_stimulus(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
        check_output("flush_level", 32'(fifo_level), 32'd0);
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check_output("flush_word", bus.word_data, 32'h01020304);
        check_output("flush_valid", 32'(bus.word_valid), 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] asynchronous reset mid-word");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check_output("pre_rst_valid", 32'(bus.word_valid), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check_output("async_valid", 32'(bus.word_valid), 32'd0);
        check_output("async_data", bus.word_data, 32'h0);
        check_output("async_level", 32'(fifo_level), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        seq[0] = 8'hDE; seq[1] = 8'hAD; seq[2] = 8'hBE; seq[3] = 8'hEF;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check_output("post_rst_word", bus.word_data, 32'hDEADBEEF);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(0, 9) < 5, 8'($urandom), $urandom_range(0, 3) == 0,
                           $urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0);
        end
        idle(100, 1'b1);
        check_output("final_valid", 32'(bus.word_valid), 32'(m_holding));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
